tensor_core_mma_seq: RTL and testbench
======================================

Name: tensor_core_mma_seq

Overview:
- Parametrised, sequential successor to the combinational 4x4 FP16 tensor-core GEMM.
- Computes C = C_init + sum over k of A[:,k] x B[k,:] as a stream of rank-1 updates, one K-step per accepted beat.
- Accumulates exactly in a Kulisch fixed-point register per output element.
- Job start/length control, valid/ready on input and output, and sticky NaN/Inf exception flags per element.

Parameters:
- NUM, 4, matrix dimension (C is NUM x NUM).
- DWIDTH, 16, FP16 element width.
- EWIDTH, 5, FP16 exponent width.
- MWIDTH, 10, FP16 stored mantissa width.
- FRAC, 48, accumulator fraction bits (LSB = 2^-48, the exact FP16 minimum product).
- AWIDTH, 92, accumulator width, two's complement (1 sign + 11 guard + 32 integer + 48 fraction).
- K_MAX, 2048, maximum beats per job; must satisfy K_MAX <= 2^(AWIDTH-FRAC-33).
- KW, $clog2(K_MAX+1), k_len width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse; sampled only in IDLE
- k_len  in  KW  number of beats in the job (0..K_MAX); sampled with start
- load_c  in  1  1: accumulators initialise from c_in; 0: initialise to zero; sampled with start
- c_in  in  NUM*NUM*AWIDTH  initial C, element [i][j]
- in_valid  in  1  beat valid
- in_ready  out  1  beat accept
- a_col  in  NUM*DWIDTH  FP16 column A[i][k]
- b_row  in  NUM*DWIDTH  FP16 row B[k][j]
- out_valid  out  1  result valid
- out_ready  in  1  result accept
- c_out  out  NUM*NUM*AWIDTH  accumulator contents
- exc_out  out  NUM*NUM  sticky NaN/Inf flag per element
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all state is cleared asynchronously on rst_n=1.
  - State goes to IDLE; in_ready, out_valid and busy go to 0.
  - c_out, exc_out, the product pipeline and the beat counter go to 0.
  - Reset mid-job aborts the job; no partial result is emitted.
- FSM states: IDLE, ACCUM, FLUSH, DONE.
  - IDLE: in_ready=0. On start, the accumulator loads c_in (load_c=1) or 0, exc clears, and the counter loads k_len. Next state is ACCUM if k_len>0, else DONE.
  - ACCUM: in_ready=1. Each handshake decrements the counter. On the handshake with counter==1, next state is FLUSH.
  - FLUSH: in_ready=0. One cycle while the last product is added. Next state is DONE.
  - DONE: out_valid=1; c_out and exc_out are held stable. On out_ready, next state is IDLE and out_valid drops the next cycle.
  - start outside IDLE is ignored. in_valid outside ACCUM is ignored.
- Pipeline: two stages.
  - Beat accepted at edge E: the NUM*NUM products are registered at E and added to the accumulators at E+1.
  - out_valid is high in the cycle after E+1, i.e. 2 cycles after the final accept.
  - Stalls (in_valid=0 in ACCUM) insert no bubbles errors: a product register with valid=0 adds nothing.
- Product arithmetic, per element (i,j), exact:
  - Effective exponent e' = exp, or 1 if exp==0. Significand m = {exp!=0, mant} (11 bits).
  - mp = ma*mb (22 bits); fixed value = mp << (ea'+eb'-2).
  - Sign = sa^sb; a negative product is subtracted.
  - ±0 and subnormals are handled naturally; -0 contributes 0.
- Exceptions: if either operand has exp==31, the product contributes 0 and exc[i][j] sets (sticky until next start).
- Accumulation: AWIDTH two's-complement add. No saturation is needed within K_MAX; wrap modulo 2^AWIDTH if the constraint is violated.

Test Plan:
- Basic: k_len=1, load_c=0, all a=0x3C00 (1.0), all b=0x4000 (2.0) -> every c_out = 2^49 (0x2000000000000); out_valid 2 cycles after accept; exc_out=0.
- Load and sign: load_c=1, all c_in=5·2^48, k_len=2, a=0xBC00 (-1.0), b=0x3C00 -> every c_out = 3·2^48.
- Extremes, k_len=2:
  - Beat 0: a[0]=b[0]=0x0001 -> contributes 1 (LSB) to c[0][0].
  - Beat 1: a[1]=b[1]=0x7BFF -> c[1][1] = 4290774016·2^48.
  - All other elements 0.
- Backpressure and exceptions:
  - k_len=4 with in_valid low on alternate cycles -> result equals the gap-free run; in_ready falls after beat 4.
  - out_ready low 5 cycles -> c_out held, out_valid stays 1.
- Exception: a[2]=0x7E00 (NaN), b=0x3C00 -> exc_out row 2 all 1, c_out row 2 = 0, other rows correct.
- Corner cases:
  - k_len=0 with load_c=1 -> DONE next cycle, c_out=c_in.
  - rst_n pulse mid-ACCUM -> all outputs 0, IDLE; a following job is correct.

Source files
------------

// File: rtl/tensor_core_mma_seq.sv
// Sequential NUM x NUM FP16 GEMM: streams rank-1 updates (one K-step per beat) into
// exact Kulisch fixed-point accumulators, with sticky NaN/Inf flags per element.
module tensor_core_mma_seq #(
    parameter int NUM    = 4,
    parameter int DWIDTH = 16,
    parameter int EWIDTH = 5,
    parameter int MWIDTH = 10,
    parameter int FRAC   = 48,
    parameter int AWIDTH = 92,
    parameter int K_MAX  = 2048,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       load_c,
    input  logic [NUM*NUM*AWIDTH-1:0]  c_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM*DWIDTH-1:0]      a_col,
    input  logic [NUM*DWIDTH-1:0]      b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM*NUM*AWIDTH-1:0]  c_out,
    output logic [NUM*NUM-1:0]         exc_out,
    output logic                       busy
);
    localparam int NE = NUM * NUM;
    // Shift that aligns a product of two significands onto the 2^-FRAC accumulator LSB.
    localparam int SHIFT_OFS = 2 * ((1 << (EWIDTH - 1)) - 1 + MWIDTH) - FRAC;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    state_t                    state, state_nx;
    logic [KW-1:0]             cnt;
    logic                      accept;
    logic                      vld_p1;
    logic signed [AWIDTH-1:0]  prod_p1 [NE];
    logic [NE-1:0]             exc_p1;
    logic signed [AWIDTH-1:0]  acc_p2 [NE];
    logic [NE-1:0]             exc_p2;

    function automatic logic is_special(input logic [DWIDTH-1:0] x);
        return &x[DWIDTH-2 -: EWIDTH];
    endfunction

    function automatic logic signed [AWIDTH-1:0] fp_prod(input logic [DWIDTH-1:0] a,
                                                         input logic [DWIDTH-1:0] b);
        logic [EWIDTH-1:0]     ea, eb;
        logic [MWIDTH:0]       ma, mb;
        logic [2*MWIDTH+1:0]   mp;
        logic [EWIDTH:0]       sh;
        logic [AWIDTH-1:0]     mag;
        ea = a[DWIDTH-2 -: EWIDTH];
        eb = b[DWIDTH-2 -: EWIDTH];
        ma = {ea != '0, a[MWIDTH-1:0]};
        mb = {eb != '0, b[MWIDTH-1:0]};
        if (ea == '0) ea = EWIDTH'(1);
        if (eb == '0) eb = EWIDTH'(1);
        mp  = {{(MWIDTH+1){1'b0}}, ma} * {{(MWIDTH+1){1'b0}}, mb};
        sh  = {1'b0, ea} + {1'b0, eb} - (EWIDTH+1)'(SHIFT_OFS);
        mag = {{(AWIDTH-2*MWIDTH-2){1'b0}}, mp} << sh;
        if (is_special(a) || is_special(b)) mag = '0;
        return (a[DWIDTH-1] ^ b[DWIDTH-1]) ? -signed'(mag) : signed'(mag);
    endfunction

    assign accept = (state == ACCUM) && in_valid;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nx = (k_len != '0) ? ACCUM : DONE;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == KW'(1)) state_nx = FLUSH;
            end
            FLUSH: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) cnt <= k_len;
            else if (accept)            cnt <= cnt - KW'(1);
        end
    end

    // Stage p1: exact signed products of the accepted beat
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vld_p1 <= 1'b0;
            exc_p1 <= '0;
            for (int e = 0; e < NE; e++) prod_p1[e] <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                for (int i = 0; i < NUM; i++) begin
                    for (int j = 0; j < NUM; j++) begin
                        prod_p1[i*NUM+j] <= fp_prod(a_col[i*DWIDTH +: DWIDTH], b_row[j*DWIDTH +: DWIDTH]);
                        exc_p1[i*NUM+j]  <= is_special(a_col[i*DWIDTH +: DWIDTH])
                                          | is_special(b_row[j*DWIDTH +: DWIDTH]);
                    end
                end
            end
        end
    end

    // Stage p2: Kulisch accumulators and sticky exception flags
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            exc_p2 <= '0;
            for (int e = 0; e < NE; e++) acc_p2[e] <= '0;
        end else if (state == IDLE && start) begin
            exc_p2 <= '0;
            for (int e = 0; e < NE; e++)
                acc_p2[e] <= load_c ? signed'(c_in[e*AWIDTH +: AWIDTH]) : '0;
        end else if (vld_p1) begin
            exc_p2 <= exc_p2 | exc_p1;
            for (int e = 0; e < NE; e++) acc_p2[e] <= acc_p2[e] + prod_p1[e];
        end
    end

    for (genvar e = 0; e < NE; e++) begin : g_out
        assign c_out[e*AWIDTH +: AWIDTH] = acc_p2[e];
    end
    assign exc_out = exc_p2;

endmodule

// File: tb/tb_tensor_core_mma_seq.sv
// Directed bench for tensor_core_mma_seq with hand-computed expected accumulator values.
module tb_tensor_core_mma_seq;
    localparam int NUM    = 4;
    localparam int DWIDTH = 16;
    localparam int AWIDTH = 92;
    localparam int KW     = 12;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      start;
    logic [KW-1:0]             k_len;
    logic                      load_c;
    logic [NUM*NUM*AWIDTH-1:0] c_in;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM*DWIDTH-1:0]     a_col;
    logic [NUM*DWIDTH-1:0]     b_row;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM*NUM*AWIDTH-1:0] c_out;
    logic [NUM*NUM-1:0]        exc_out;
    logic                      busy;

    int chk_cnt = 0;
    int err_cnt = 0;
    logic [AWIDTH-1:0] expv;
    logic [NUM*DWIDTH-1:0] av;

    always #5 clk = ~clk;

    tensor_core_mma_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .load_c(load_c),
        .c_in(c_in), .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col),
        .b_row(b_row), .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out),
        .exc_out(exc_out), .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AWIDTH-1:0] c_el(input int i, input int j);
        return c_out[(i*NUM+j)*AWIDTH +: AWIDTH];
    endfunction

    task automatic start_job(input logic [KW-1:0] k, input logic lc);
        @(negedge clk);
        start = 1'b1; k_len = k; load_c = lc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [NUM*DWIDTH-1:0] a, input logic [NUM*DWIDTH-1:0] b, input int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        a_col = a; b_row = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("beat_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        chk("done_wait", 128'(out_valid), 128'(1));
    endtask

    task automatic finish_job();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("ack_ov", 128'(out_valid), 128'(0));
        chk("ack_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; k_len = '0; load_c = 1'b0; c_in = '0;
        in_valid = 1'b0; a_col = '0; b_row = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_c00", 128'(c_el(0, 0)), 128'(0));
        chk("rst_exc", 128'(exc_out), 128'(0));

        // Basic: 1.0 * 2.0 = 2^49 in every element, latency 2 cycles
        start_job(12'd1, 1'b0);
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_ready", 128'(in_ready), 128'(1));
        beat({4{16'h3C00}}, {4{16'h4000}}, 0);
        @(negedge clk);
        chk("t1_flush_ov", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("t1_lat_ov", 128'(out_valid), 128'(1));
        expv = AWIDTH'(1) << 49;
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM; j++)
                chk($sformatf("t1_c%0d%0d", i, j), 128'(c_el(i, j)), 128'(expv));
        chk("t1_exc", 128'(exc_out), 128'(0));
        finish_job();

        // Load and sign: 5 + 2*(-1) = 3 (units of 2^48)
        for (int e = 0; e < NUM*NUM; e++) c_in[e*AWIDTH +: AWIDTH] = AWIDTH'(5) << 48;
        start_job(12'd2, 1'b1);
        beat({4{16'hBC00}}, {4{16'h3C00}}, 0);
        beat({4{16'hBC00}}, {4{16'h3C00}}, 0);
        wait_done();
        expv = AWIDTH'(3) << 48;
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM; j++)
                chk($sformatf("t2_c%0d%0d", i, j), 128'(c_el(i, j)), 128'(expv));
        finish_job();

        // Extremes: min subnormal squared and max normal squared
        start_job(12'd2, 1'b0);
        beat({48'h0, 16'h0001}, {48'h0, 16'h0001}, 0);
        beat({32'h0, 16'h7BFF, 16'h0}, {32'h0, 16'h7BFF, 16'h0}, 0);
        wait_done();
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM; j++) begin
                if (i == 0 && j == 0)      expv = AWIDTH'(1);
                else if (i == 1 && j == 1) expv = AWIDTH'(64'd4290774016) << 48;
                else                       expv = '0;
                chk($sformatf("t3_c%0d%0d", i, j), 128'(c_el(i, j)), 128'(expv));
            end
        finish_job();

        // Backpressure: a rows 1,2,3,4 times 1.0, four beats with input gaps
        av = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        start_job(12'd4, 1'b0);
        for (int n = 0; n < 4; n++) beat(av, {4{16'h3C00}}, (n == 0) ? 0 : 1);
        @(negedge clk);
        chk("t4_ready_drop", 128'(in_ready), 128'(0));
        wait_done();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("t4_hold_ov", 128'(out_valid), 128'(1));
            chk("t4_hold_c30", 128'(c_el(3, 0)), 128'(AWIDTH'(16) << 48));
        end
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM; j++) begin
                expv = AWIDTH'(4 * (i + 1)) << 48;
                chk($sformatf("t4_c%0d%0d", i, j), 128'(c_el(i, j)), 128'(expv));
            end
        finish_job();

        // NaN in a[2]: row 2 flagged and contributes nothing
        start_job(12'd1, 1'b0);
        beat({16'h3C00, 16'h7E00, 16'h3C00, 16'h3C00}, {4{16'h3C00}}, 0);
        wait_done();
        chk("t5_exc", 128'(exc_out), 128'(16'h0F00));
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM; j++) begin
                expv = (i == 2) ? '0 : (AWIDTH'(1) << 48);
                chk($sformatf("t5_c%0d%0d", i, j), 128'(c_el(i, j)), 128'(expv));
            end
        finish_job();

        // k_len = 0 with load_c: straight to DONE with c_out = c_in, exc cleared
        for (int e = 0; e < NUM*NUM; e++) c_in[e*AWIDTH +: AWIDTH] = AWIDTH'(e * 7 + 1) << 20;
        start_job(12'd0, 1'b1);
        chk("t6_ov", 128'(out_valid), 128'(1));
        chk("t6_exc", 128'(exc_out), 128'(0));
        for (int e = 0; e < NUM*NUM; e++)
            chk($sformatf("t6_c%0d", e), 128'(c_out[e*AWIDTH +: AWIDTH]), 128'(AWIDTH'(e * 7 + 1) << 20));
        finish_job();

        // Reset mid-ACCUM aborts the job, then a fresh job runs cleanly
        start_job(12'd3, 1'b0);
        beat({4{16'h3C00}}, {4{16'h3C00}}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_busy", 128'(busy), 128'(0));
        chk("t7_ready", 128'(in_ready), 128'(0));
        chk("t7_ov", 128'(out_valid), 128'(0));
        chk("t7_c00", 128'(c_el(0, 0)), 128'(0));
        chk("t7_exc", 128'(exc_out), 128'(0));
        rst_n = 1'b0;
        start_job(12'd1, 1'b0);
        beat({4{16'h3C00}}, {4{16'h4000}}, 0);
        wait_done();
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < NUM; j++)
                chk($sformatf("t7_c%0d%0d", i, j), 128'(c_el(i, j)), 128'(AWIDTH'(1) << 49));
        finish_job();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
